stage_d: RTL and testbench

//  Decode/register-read stage directly downstream of the instruction fetch stage.
//  - Consumes one fetched instruction per cycle (valid, instr, pc, npc).
//  - Decodes MIPS-I fields and reads the 32x32 register file.
//  - Presents a registered decoded bundle to the execute stage.
//  - Has no stall wire: a load-use hazard is resolved by replaying, i.e. restarting fetch at the hazard PC.

---
 rtl/stage_d.sv | 143 ++++++++++++++
 tb/tb_stage_d.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/stage_d.sv
// Decode / register-read stage: decodes MIPS-I fields, reads the 32x32 GPR file and
// presents a registered bundle to execute; load-use hazards are resolved by a fetch restart.
module stage_d #(
  parameter int    debug   = 0,
  parameter string RF_INIT = ""
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        i_valid,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_npc,
  input  logic        kill,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        d_valid,
  output logic [31:0] d_pc,
  output logic [31:0] d_npc,
  output logic [31:0] d_instr,
  output logic [31:0] d_op1,
  output logic [31:0] d_op2,
  output logic [31:0] d_simm,
  output logic [31:0] d_target,
  output logic [4:0]  d_wbr,
  output logic        d_is_load,
  output logic        d_is_store,
  output logic        d_is_branch,
  output logic        d_restart,
  output logic [31:0] d_restart_pc
);

  // Trace printing and file preload live in simulation wrappers, not in this view.
  if (debug != 0 || RF_INIT != "") begin : g_sim_hooks
  end

  logic [31:0] rf [32];

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic        is_special;
  logic        is_regimm;
  logic        is_load;
  logic        is_store;
  logic        is_branch;
  logic        is_jr;
  logic        uses_rt;
  logic [4:0]  wbr;
  logic [31:0] op1_val;
  logic [31:0] op2_val;
  logic        hz;

  assign op    = i_instr[31:26];
  assign rs    = i_instr[25:21];
  assign rt    = i_instr[20:16];
  assign rd    = i_instr[15:11];
  assign funct = i_instr[5:0];

  always_comb begin
    is_special = (op == 6'h00);
    is_regimm  = (op == 6'h01);
    is_jr      = is_special && (funct == 6'h08);
    is_load    = (op[5:3] == 3'b100) && (op != 6'h27);
    is_store   = (op == 6'h28) || (op == 6'h29) || (op == 6'h2a) ||
                 (op == 6'h2b) || (op == 6'h2e);
    is_branch  = ((op >= 6'h01) && (op <= 6'h07)) ||
                 (is_special && ((funct == 6'h08) || (funct == 6'h09)));
    uses_rt    = is_special || (op == 6'h04) || (op == 6'h05) || is_store;

    wbr = 5'd0;
    if (is_special && !is_jr)
      wbr = rd;
    else if ((op == 6'h03) || (is_regimm && ((rt == 5'd16) || (rt == 5'd17))))
      wbr = 5'd31;
    else if ((op[5:3] == 3'b001) || is_load)
      wbr = rt;
  end

  // Write-through: a same-cycle writeback is visible to the instruction being decoded.
  always_comb begin
    op1_val = '0;
    op2_val = '0;
    if (rs != 5'd0)
      op1_val = (wb_en && (wb_rd == rs)) ? wb_data : rf[rs];
    if (rt != 5'd0)
      op2_val = (wb_en && (wb_rd == rt)) ? wb_data : rf[rt];
  end

  assign hz = i_valid && d_valid && d_is_load && (d_wbr != 5'd0) &&
              ((d_wbr == rs) || (uses_rt && (d_wbr == rt)));

  // The register file is never reset; r0 is never written and always reads as zero.
  always_ff @(posedge clock) begin
    if (wb_en && (wb_rd != 5'd0))
      rf[wb_rd] <= wb_data;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      d_valid      <= 1'b0;
      d_pc         <= '0;
      d_npc        <= '0;
      d_instr      <= '0;
      d_op1        <= '0;
      d_op2        <= '0;
      d_simm       <= '0;
      d_target     <= '0;
      d_wbr        <= '0;
      d_is_load    <= 1'b0;
      d_is_store   <= 1'b0;
      d_is_branch  <= 1'b0;
      d_restart    <= 1'b0;
      d_restart_pc <= '0;
    end else begin
      d_pc        <= i_pc;
      d_npc       <= i_npc;
      d_instr     <= i_instr;
      d_op1       <= op1_val;
      d_op2       <= op2_val;
      d_simm      <= {{16{i_instr[15]}}, i_instr[15:0]};
      d_target    <= {i_npc[31:28], i_instr[25:0], 2'b00};
      d_wbr       <= wbr;
      d_is_load   <= is_load;
      d_is_store  <= is_store;
      d_is_branch <= is_branch;
      if (kill) begin
        d_valid   <= 1'b0;
        d_restart <= 1'b0;
      end else if (hz) begin
        d_valid      <= 1'b0;
        d_restart    <= 1'b1;
        d_restart_pc <= i_pc;
      end else begin
        d_valid   <= i_valid;
        d_restart <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stage_d.sv
// Directed bench for stage_d: reset, bypass, load-use replay, kill and decode fields.
module tb_stage_d;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        i_valid;
  logic [31:0] i_instr;
  logic [31:0] i_pc;
  logic [31:0] i_npc;
  logic        kill;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        d_valid;
  logic [31:0] d_pc;
  logic [31:0] d_npc;
  logic [31:0] d_instr;
  logic [31:0] d_op1;
  logic [31:0] d_op2;
  logic [31:0] d_simm;
  logic [31:0] d_target;
  logic [4:0]  d_wbr;
  logic        d_is_load;
  logic        d_is_store;
  logic        d_is_branch;
  logic        d_restart;
  logic [31:0] d_restart_pc;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  stage_d dut (
    .clock(clock), .reset_n(reset_n), .i_valid(i_valid), .i_instr(i_instr),
    .i_pc(i_pc), .i_npc(i_npc), .kill(kill), .wb_en(wb_en), .wb_rd(wb_rd),
    .wb_data(wb_data), .d_valid(d_valid), .d_pc(d_pc), .d_npc(d_npc),
    .d_instr(d_instr), .d_op1(d_op1), .d_op2(d_op2), .d_simm(d_simm),
    .d_target(d_target), .d_wbr(d_wbr), .d_is_load(d_is_load),
    .d_is_store(d_is_store), .d_is_branch(d_is_branch), .d_restart(d_restart),
    .d_restart_pc(d_restart_pc)
  );

  function automatic logic [31:0] r_type(input int rs, input int rt, input int rd, input int fn);
    r_type = {6'h00, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn[5:0]};
  endfunction

  function automatic logic [31:0] i_type(input int op, input int rs, input int rt, input logic [15:0] imm);
    i_type = {op[5:0], rs[4:0], rt[4:0], imm};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic k, input logic we, input int rd, input logic [31:0] wd);
    i_valid = v;
    i_instr = ins;
    i_pc    = pc;
    i_npc   = pc + 32'd4;
    kill    = k;
    wb_en   = we;
    wb_rd   = rd[4:0];
    wb_data = wd;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    step(1'b1, r_type(1, 2, 3, 'h21), 32'h40, 1'b0, 1'b0, 0, 32'h0);
    step(1'b1, r_type(1, 2, 3, 'h21), 32'h44, 1'b0, 1'b0, 0, 32'h0);
    check("rst_valid",   {31'd0, d_valid},   32'd0);
    check("rst_restart", {31'd0, d_restart}, 32'd0);
    check("rst_wbr",     {27'd0, d_wbr},     32'd0);
    reset_n = 1'b1;

    // r0 read
    step(1'b1, r_type(0, 0, 7, 'h21), 32'h80, 1'b0, 1'b0, 0, 32'h0);
    check("r0_op1",   d_op1, 32'h0);
    check("r0_valid", {31'd0, d_valid}, 32'd1);
    check("r0_wbr",   {27'd0, d_wbr}, 32'd7);

    // Same-cycle bypass on both read ports
    step(1'b1, r_type(5, 5, 6, 'h21), 32'h100, 1'b0, 1'b1, 5, 32'h1234);
    check("byp_op1",   d_op1, 32'h1234);
    check("byp_op2",   d_op2, 32'h1234);
    check("byp_wbr",   {27'd0, d_wbr}, 32'd6);
    check("byp_valid", {31'd0, d_valid}, 32'd1);
    check("byp_pc",    d_pc, 32'h100);
    check("byp_npc",   d_npc, 32'h104);

    // Committed value read back from the array
    step(1'b1, r_type(5, 0, 2, 'h21), 32'h104, 1'b0, 1'b0, 0, 32'h0);
    check("rf_op1", d_op1, 32'h1234);

    // Bubble with a write still commits
    step(1'b0, r_type(5, 5, 6, 'h21), 32'h108, 1'b0, 1'b1, 1, 32'h11);
    check("bub_valid", {31'd0, d_valid}, 32'd0);
    step(1'b1, i_type(9, 1, 4, 16'h0000), 32'h10c, 1'b0, 1'b1, 0, 32'hdead);
    check("bub_wr_op1", d_op1, 32'h11);
    step(1'b1, r_type(0, 0, 3, 'h21), 32'h110, 1'b0, 1'b1, 0, 32'hbeef);
    check("r0_byp_op1", d_op1, 32'h0);
    check("r0_wr_op2",  d_op2, 32'h0);

    // Load-use on rs
    step(1'b1, i_type(35, 4, 8, 16'h0000), 32'h200, 1'b0, 1'b0, 0, 32'h0);
    check("lw_load", {31'd0, d_is_load}, 32'd1);
    check("lw_wbr",  {27'd0, d_wbr}, 32'd8);
    step(1'b1, r_type(8, 1, 9, 'h21), 32'h204, 1'b0, 1'b0, 0, 32'h0);
    check("hz_valid",   {31'd0, d_valid}, 32'd0);
    check("hz_restart", {31'd0, d_restart}, 32'd1);
    check("hz_rpc",     d_restart_pc, 32'h204);
    step(1'b0, 32'h0, 32'h208, 1'b0, 1'b0, 0, 32'h0);
    check("hz_one_cycle", {31'd0, d_restart}, 32'd0);
    step(1'b1, r_type(8, 1, 9, 'h21), 32'h204, 1'b0, 1'b0, 0, 32'h0);
    check("replay_valid",   {31'd0, d_valid}, 32'd1);
    check("replay_restart", {31'd0, d_restart}, 32'd0);

    // Load-use through rt of a store
    step(1'b1, i_type(35, 4, 8, 16'h0000), 32'h220, 1'b0, 1'b0, 0, 32'h0);
    step(1'b1, i_type(43, 2, 8, 16'h0000), 32'h224, 1'b0, 1'b0, 0, 32'h0);
    check("st_hz_restart", {31'd0, d_restart}, 32'd1);
    check("st_hz_rpc",     d_restart_pc, 32'h224);
    step(1'b0, 32'h0, 32'h228, 1'b0, 1'b0, 0, 32'h0);

    // No false hazards
    step(1'b1, i_type(35, 4, 8, 16'h0000), 32'h240, 1'b0, 1'b0, 0, 32'h0);
    step(1'b1, i_type(9, 1, 9, 16'h0001), 32'h244, 1'b0, 1'b0, 0, 32'h0);
    check("nh_restart", {31'd0, d_restart}, 32'd0);
    check("nh_wbr",     {27'd0, d_wbr}, 32'd9);
    check("nh_valid",   {31'd0, d_valid}, 32'd1);
    step(1'b1, i_type(35, 4, 8, 16'h0000), 32'h248, 1'b0, 1'b0, 0, 32'h0);
    step(1'b1, i_type(9, 1, 8, 16'h0001), 32'h24c, 1'b0, 1'b0, 0, 32'h0);
    check("nh_rtdst_restart", {31'd0, d_restart}, 32'd0);
    step(1'b1, i_type(35, 4, 0, 16'h0000), 32'h250, 1'b0, 1'b0, 0, 32'h0);
    step(1'b1, r_type(0, 0, 9, 'h21), 32'h254, 1'b0, 1'b0, 0, 32'h0);
    check("nh_r0_restart", {31'd0, d_restart}, 32'd0);
    check("nh_r0_valid",   {31'd0, d_valid}, 32'd1);

    // Kill overrides a pending hazard; the concurrent write still lands
    step(1'b1, i_type(35, 4, 8, 16'h0000), 32'h300, 1'b0, 1'b0, 0, 32'h0);
    step(1'b1, r_type(8, 1, 9, 'h21), 32'h304, 1'b1, 1'b1, 10, 32'h55aa);
    check("kill_restart", {31'd0, d_restart}, 32'd0);
    check("kill_valid",   {31'd0, d_valid}, 32'd0);
    step(1'b1, r_type(10, 0, 11, 'h21), 32'h308, 1'b0, 1'b0, 0, 32'h0);
    check("kill_wr_op1",  d_op1, 32'h55aa);
    check("kill_after_restart", {31'd0, d_restart}, 32'd0);

    // Decode fields
    step(1'b1, 32'h0c10_0000, 32'h1000, 1'b0, 1'b0, 0, 32'h0);
    check("jal_wbr",    {27'd0, d_wbr}, 32'd31);
    check("jal_branch", {31'd0, d_is_branch}, 32'd1);
    check("jal_target", d_target, 32'h0040_0000);
    step(1'b1, i_type(33, 2, 3, 16'hfffc), 32'h1004, 1'b0, 1'b0, 0, 32'h0);
    check("lh_simm", d_simm, 32'hffff_fffc);
    check("lh_load", {31'd0, d_is_load}, 32'd1);
    check("lh_wbr",  {27'd0, d_wbr}, 32'd3);
    step(1'b1, i_type(1, 4, 16, 16'h0010), 32'h1008, 1'b0, 1'b0, 0, 32'h0);
    check("bltzal_wbr",    {27'd0, d_wbr}, 32'd31);
    check("bltzal_branch", {31'd0, d_is_branch}, 32'd1);
    step(1'b1, i_type(41, 2, 3, 16'h0002), 32'h100c, 1'b0, 1'b0, 0, 32'h0);
    check("sh_store", {31'd0, d_is_store}, 32'd1);
    check("sh_wbr",   {27'd0, d_wbr}, 32'd0);
    step(1'b1, r_type(31, 0, 0, 'h08), 32'h1010, 1'b0, 1'b0, 0, 32'h0);
    check("jr_branch", {31'd0, d_is_branch}, 32'd1);
    check("jr_wbr",    {27'd0, d_wbr}, 32'd0);

    // Reset mid-stream clears outputs but not the register file
    reset_n = 1'b0;
    step(1'b1, r_type(1, 2, 3, 'h21), 32'h2000, 1'b0, 1'b0, 0, 32'h0);
    check("rst2_valid", {31'd0, d_valid}, 32'd0);
    check("rst2_wbr",   {27'd0, d_wbr}, 32'd0);
    reset_n = 1'b1;
    step(1'b1, r_type(5, 10, 12, 'h21), 32'h2004, 1'b0, 1'b0, 0, 32'h0);
    check("rst2_keep_op1", d_op1, 32'h1234);
    check("rst2_keep_op2", d_op2, 32'h55aa);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
